tlc1549_ctrl: RTL
=================

# tlc1549_ctrl

Serial-ADC front end that drives a TLC1549-class 10-bit serial converter and delivers parallel samples on `ad_data`, the bus consumed by the amplitude/min-max measurement logic. A free-running sample timer launches one conversion frame per period. The FSM generates chip select and serial clock, shifts in the 10-bit result MSB first, waits out the conversion time, then presents the word with a one-cycle valid strobe.

## Interface
- `CLK_DIV`, 25: system clocks per SCLK half-period (50 MHz → 1 MHz SCLK).
- `CS_SETUP_CYC`, 50: clocks from `adc_cs_n` fall to first SCLK rise phase.
- `CONV_CYC`, 1100: clocks held idle after the 10th SCLK for conversion (≥21 µs at 50 MHz).
- `SAMPLE_DIV`, 2500: clocks per sample period (20 kS/s).
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset; one clock, synchronous, active-high.
- `adc_dout` in 1: serial data from ADC.
- `adc_cs_n` out 1: ADC chip select, active low.
- `adc_sclk` out 1: ADC I/O clock.
- `ad_data` out 10: last completed sample, held between strobes.
- `ad_valid` out 1: one-cycle strobe, `ad_data` new this cycle.
- `busy` out 1: high whenever FSM not in IDLE.
- `overrun` out 1: one-cycle pulse when a sample tick arrives while busy.

## Operation
- Timer counts 0..SAMPLE_DIV-1 and wraps. `tick` is high when the count equals SAMPLE_DIV-1.
- FSM states: IDLE, SETUP, SHIFT, CONV, DONE.
- IDLE → SETUP on `tick`. SETUP drives `adc_cs_n`=0 and clears the bit counter and phase counter.
- SETUP → SHIFT after CS_SETUP_CYC clocks.
- SHIFT runs 10 SCLK periods, each 2·CLK_DIV clocks: `adc_sclk`=0 for the first CLK_DIV clocks, then 1 for CLK_DIV clocks.
- On the clock where `adc_sclk` goes 0→1, `adc_dout` is shifted into the shift register LSB (first bit = MSB).
- After the 10th high phase completes: SHIFT → CONV, with `adc_sclk`=0 and `adc_cs_n`=1.
- CONV → DONE after CONV_CYC clocks.
- DONE (one cycle): `ad_data` ← shift register, `ad_valid`=1, then → IDLE.
- The converter returns the previous conversion's result. The first frame after reset is therefore discarded: it runs fully, but `ad_data` and `ad_valid` are not updated.
- A `tick` in any state other than IDLE is dropped and pulses `overrun`. The frame in progress is unaffected. The next frame starts on the next tick.
- `rst` mid-frame aborts immediately: all outputs return to reset values, the timer restarts at 0, and the discard flag is re-armed.

## Timing
- Reset values: `adc_cs_n`=1, `adc_sclk`=0, `ad_data`=0, `ad_valid`=0, `busy`=0, `overrun`=0. Timer=0, state=IDLE.
- First tick occurs SAMPLE_DIV-1 clocks after `rst` deasserts.
- Tick at cycle T: `adc_cs_n` falls at T+1. First SCLK rise at T+1+CS_SETUP_CYC+CLK_DIV.
- `ad_valid` at T+L, where L = 1+CS_SETUP_CYC+20·CLK_DIV+CONV_CYC (default 1651).
- SAMPLE_DIV must exceed L+1 for loss-free operation; otherwise `overrun` fires on every other tick.
- All outputs are registered; no combinational path from `adc_dout` to any output.

## Configuration
- `ADC_AVG4_EN` defined:
  - A 12-bit accumulator sums four consecutive non-discarded samples.
  - On every 4th DONE: `ad_data` ← sum[11:2], `ad_valid` pulses, and the accumulator clears.
  - DONE cycles that do not complete a group of four produce no strobe.
  - Reset clears the accumulator and the group counter.
- Undefined: every non-discarded frame produces a strobe carrying the raw sample.

## Structure
- Package `adc_pkg`: FSM state enum, `ADC_BITS`=10, accumulator width 12, default timing constants.
- Sub-module `sample_tick_gen`: parameterised modulo counter with a `tick` output and synchronous active-high reset; instantiated once.

## Test plan
- Reset, then ADC model returns 10'h2A5 each frame → first frame gives no `ad_valid`; second frame gives `ad_valid` with `ad_data`=10'h2A5 exactly 1651 clocks after its tick; 20 SCLK edges per frame.
- Model returns sequence 0, 1023, 512 → `ad_data` strobes show 1023 then 512 (0 discarded as the first frame). SCLK high and low times are each 25 clocks.
- SAMPLE_DIV=1000 (< L) → `overrun` pulses on alternate ticks; valid frames complete without corruption.
- Assert `rst` for 1 clock mid-SHIFT (bit 5) → `adc_cs_n`=1 and `adc_sclk`=0 next cycle; the next post-reset frame is discarded.
- `ADC_AVG4_EN`, samples 100, 101, 102, 105 after the discard → single strobe with `ad_data`=102 (408>>2), none in between.
- `ADC_AVG4_EN`, four samples of 1023 → `ad_data`=1023, no accumulator overflow.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the TLC1549 serial-ADC front end: FSM state
// encoding, sample/accumulator widths and default frame timing.
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_CONV,
        ST_DONE
    } adc_state_t;

    localparam int ADC_BITS = 10;
    localparam int ACC_W    = 12;

    localparam int DEF_CLK_DIV      = 25;
    localparam int DEF_CS_SETUP_CYC = 50;
    localparam int DEF_CONV_CYC     = 1100;
    localparam int DEF_SAMPLE_DIV   = 2500;

    // Largest of three values; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running modulo-DIV counter. tick is high for the single cycle in
// which the count sits at DIV-1, i.e. once per DIV clocks.
module sample_tick_gen #(
    parameter int DIV = 2500
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    // Count 0..DIV-1 and wrap; reset restarts the period from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count == CW'(DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == CW'(DIV - 1));

endmodule

// File: rtl/tlc1549_ctrl.sv
// TLC1549-class serial ADC front end. One frame per sample tick: assert
// chip select, clock in 10 bits MSB first, wait out the conversion, then
// strobe the word onto ad_data. The converter returns the previous
// conversion's result, so the first frame after reset is thrown away.
// Build option ADC_AVG4_EN: average four consecutive samples per strobe.
module tlc1549_ctrl
    import adc_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
    parameter int CONV_CYC     = DEF_CONV_CYC,
    parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adc_dout,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic [ADC_BITS-1:0] ad_data,
    output logic                ad_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int CNT_MAX = max3(CS_SETUP_CYC, 2 * CLK_DIV, CONV_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic                tick;
    adc_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [3:0]          bit_cnt;
    logic [ADC_BITS-1:0] shreg;
    logic                discard;

`ifdef ADC_AVG4_EN
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [1:0]          grp;

    assign acc_next = acc + ACC_W'(shreg);
`endif

    sample_tick_gen #(
        .DIV (SAMPLE_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Frame sequencer; every output is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            discard  <= 1'b1;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            ad_data  <= '0;
            ad_valid <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
`ifdef ADC_AVG4_EN
            acc      <= '0;
            grp      <= '0;
`endif
        end else begin
            ad_valid <= 1'b0;
            // A tick that finds the sequencer busy is lost, only flagged.
            overrun  <= tick && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state    <= ST_SETUP;
                        adc_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                    end
                end

                ST_SETUP: begin
                    if (cnt == CNT_W'(CS_SETUP_CYC - 1)) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_SHIFT: begin
                    // Each SCLK period: CLK_DIV clocks low, then CLK_DIV high.
                    // Data is captured on the clock that raises SCLK; the ADC
                    // has had the whole low phase to settle it.
                    if (cnt == CNT_W'(CLK_DIV - 1)) begin
                        adc_sclk <= 1'b1;
                        shreg    <= {shreg[ADC_BITS-2:0], adc_dout};
                        cnt      <= cnt + CNT_W'(1);
                    end else if (cnt == CNT_W'(2 * CLK_DIV - 1)) begin
                        adc_sclk <= 1'b0;
                        cnt      <= '0;
                        if (bit_cnt == 4'(ADC_BITS - 1)) begin
                            state    <= ST_CONV;
                            adc_cs_n <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_CONV: begin
                    if (cnt == CNT_W'(CONV_CYC - 1)) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                        // Result lands in the DONE cycle; the stale word of
                        // the first frame after reset is never presented.
                        if (!discard) begin
`ifdef ADC_AVG4_EN
                            if (grp == 2'd3) begin
                                ad_data  <= acc_next[ACC_W-1:2];
                                ad_valid <= 1'b1;
                                acc      <= '0;
                                grp      <= '0;
                            end else begin
                                acc <= acc_next;
                                grp <= grp + 2'd1;
                            end
`else
                            ad_data  <= shreg;
                            ad_valid <= 1'b1;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    discard <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end

                default: begin
                    state    <= ST_IDLE;
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
